// File: rtl/conv_stream_serializer.sv
// conv_stream_serializer
// Takes P-pixel beats from the parallel convolver, masks invalid lanes to
// zero, buffers the words in a small FIFO and replays them as a
// one-pixel-per-cycle ready/valid raster stream with frame/line markers.

module conv_stream_serializer #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256,
   parameter int P      = 4,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       beat_valid,
   input  logic [P-1:0]               lane_valid,
   input  logic [P*8-1:0]             pix_vec,
   input  logic                       m_ready,
   output logic                       m_valid,
   output logic [7:0]                 m_pix,
   output logic                       m_sof,
   output logic                       m_eol,
   output logic                       m_eof,
   output logic                       frame_done,
   output logic                       overflow,
   output logic [$clog2(DEPTH+1)-1:0] fill_level
);

   localparam int FLW  = $clog2(DEPTH + 1);
   localparam int PTRW = $clog2(DEPTH);
   localparam int LPW  = (P > 1) ? $clog2(P) : 1;
   localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int NLANESLOT = 2 ** LPW;

   localparam logic [FLW-1:0] FILL_FULL = FLW'(DEPTH);
   localparam logic [LPW-1:0] LANE_LAST = LPW'(P - 1);
   localparam logic [CW-1:0]  COL_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0]  ROW_LAST  = RW'(HEIGHT - 1);

   logic [P*8-1:0]  mem_q [DEPTH];
   logic [PTRW-1:0] wrPtr_q, wrPtr_d;
   logic [PTRW-1:0] rdPtr_q, rdPtr_d;
   logic [FLW-1:0]  count_q, count_d;
   logic [LPW-1:0]  lp_q, lp_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic            frameDone_q, frameDone_d;
   logic            overflow_q, overflow_d;

   logic [P*8-1:0]  pushWord;
   logic [7:0]      headLanes [NLANESLOT];
   logic            xfer;
   logic            lastLane;
   logic            popNow;
   logic            pushAcc;
   logic            atColEnd;
   logic            atRowEnd;

   // Build the word to store: any lane that is not flagged valid, or whose
   // pixel bits are not cleanly 0/1, is forced to zero so the frame keeps
   // its full pixel count.
   always_comb begin
      pushWord = '0;
      for (int l = 0; l < P; l++) begin
         if ((lane_valid[l] === 1'b1) && !$isunknown(pix_vec[l*8 +: 8])) begin
            pushWord[l*8 +: 8] = pix_vec[l*8 +: 8];
         end
      end
   end

   // Split the head word into per-lane bytes; unused slots read as zero so
   // the lane pointer can index the array for every legal P.
   always_comb begin
      for (int l = 0; l < NLANESLOT; l++) begin
         headLanes[l] = 8'd0;
      end
      for (int l = 0; l < P; l++) begin
         headLanes[l] = mem_q[rdPtr_q][l*8 +: 8];
      end
   end

   // Handshake, marker decode and FIFO accept/pop decisions, all derived
   // from registered state so nothing downstream sees a path from m_ready
   // into the data or markers.
   always_comb begin
      m_valid  = (count_q != '0);
      m_pix    = m_valid ? headLanes[lp_q] : 8'd0;
      xfer     = m_valid && m_ready;
      lastLane = (lp_q == LANE_LAST);
      popNow   = xfer && lastLane;
      pushAcc  = beat_valid && ((count_q != FILL_FULL) || popNow);
      atColEnd = (col_q == COL_LAST);
      atRowEnd = (row_q == ROW_LAST);
      m_sof    = m_valid && (col_q == '0) && (row_q == '0);
      m_eol    = m_valid && atColEnd;
      m_eof    = m_valid && atColEnd && atRowEnd;
   end

   // Next-state for pointers, occupancy, lane pointer, raster position and
   // status flags.
   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      lp_d        = lp_q;
      col_d       = col_q;
      row_d       = row_q;
      frameDone_d = 1'b0;
      overflow_d  = overflow_q;

      if (pushAcc) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (popNow) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end

      case ({pushAcc, popNow})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (xfer) begin
         lp_d = lastLane ? '0 : lp_q + 1'b1;
         if (atColEnd) begin
            col_d = '0;
            row_d = atRowEnd ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         frameDone_d = atColEnd && atRowEnd;
      end

      if (beat_valid && !pushAcc) begin
         overflow_d = 1'b1;
      end
   end

   // Word storage; stale contents after reset are harmless because the
   // pointers and occupancy are cleared.
   always_ff @(posedge clk) begin
      if (pushAcc) begin
         mem_q[wrPtr_q] <= pushWord;
      end
   end

   // Control state register with synchronous active-low reset that drops
   // all buffered data and restarts the raster at a new frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         lp_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
         frameDone_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         lp_q        <= lp_d;
         col_q       <= col_d;
         row_q       <= row_d;
         frameDone_q <= frameDone_d;
         overflow_q  <= overflow_d;
      end
   end

   assign frame_done = frameDone_q;
   assign overflow   = overflow_q;
   assign fill_level = count_q;

endmodule

// File: tb/tb_conv_stream_serializer.sv
// tb_conv_stream_serializer
// Directed and randomized stimulus for conv_stream_serializer, checked every
// cycle against a pixel-queue reference model of the serialized stream.

module tb_conv_stream_serializer;

   localparam int WIDTH  = 8;
   localparam int HEIGHT = 2;
   localparam int P      = 4;
   localparam int DEPTH  = 16;
   localparam int FRAME  = WIDTH * HEIGHT;
   localparam int FLW    = $clog2(DEPTH + 1);

   logic           clk = 1'b0;
   logic           rst_n;
   logic           beat_valid;
   logic [P-1:0]   lane_valid;
   logic [P*8-1:0] pix_vec;
   logic           m_ready;
   logic           m_valid;
   logic [7:0]     m_pix;
   logic           m_sof;
   logic           m_eol;
   logic           m_eof;
   logic           frame_done;
   logic           overflow;
   logic [FLW-1:0] fill_level;

   logic [7:0] pixQ [$];
   int         pixIdx;
   bit         expOvf;
   bit         expDone;
   bit         checking;
   int         checks;
   int         errors;

   conv_stream_serializer #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .P     (P),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .beat_valid(beat_valid),
      .lane_valid(lane_valid),
      .pix_vec   (pix_vec),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_pix     (m_pix),
      .m_sof     (m_sof),
      .m_eol     (m_eol),
      .m_eof     (m_eof),
      .frame_done(frame_done),
      .overflow  (overflow),
      .fill_level(fill_level)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic bv, input logic [P-1:0] lv,
                                input logic [P*8-1:0] pv, input logic rdy);
      rst_n      = rst;
      beat_valid = bv;
      lane_valid = lv;
      pix_vec    = pv;
      m_ready    = rdy;
   endtask

   // One clock: compare outputs with the model mid-cycle, then advance the
   // model by what this cycle's inputs do at the coming rising edge.
   task automatic tick();
      int   sz;
      int   fill;
      bit   xfer;
      bit   accept;
      logic [7:0] b;
      @(negedge clk);
      sz   = pixQ.size();
      fill = (sz + P - 1) / P;
      if (checking) begin
         checkOutput("m_valid",    32'(m_valid),    32'(sz > 0));
         checkOutput("m_pix",      32'(m_pix),      (sz > 0) ? 32'(pixQ[0]) : 32'd0);
         checkOutput("m_sof",      32'(m_sof),      32'((sz > 0) && (pixIdx == 0)));
         checkOutput("m_eol",      32'(m_eol),      32'((sz > 0) && (pixIdx % WIDTH == WIDTH - 1)));
         checkOutput("m_eof",      32'(m_eof),      32'((sz > 0) && (pixIdx == FRAME - 1)));
         checkOutput("fill_level", 32'(fill_level), 32'(fill));
         checkOutput("overflow",   32'(overflow),   32'(expOvf));
         checkOutput("frame_done", 32'(frame_done), 32'(expDone));
      end
      if (!rst_n) begin
         pixQ.delete();
         pixIdx  = 0;
         expOvf  = 1'b0;
         expDone = 1'b0;
      end else begin
         xfer    = (sz > 0) && (m_ready === 1'b1);
         expDone = xfer && (pixIdx == FRAME - 1);
         accept  = beat_valid && ((fill < DEPTH) || (xfer && (sz % P == 1)));
         if (beat_valid && !accept) expOvf = 1'b1;
         if (xfer) begin
            void'(pixQ.pop_front());
            pixIdx = (pixIdx + 1) % FRAME;
         end
         if (accept) begin
            for (int l = 0; l < P; l++) begin
               b = pix_vec[l*8 +: 8];
               pixQ.push_back(((lane_valid[l] === 1'b1) && !$isunknown(b)) ? b : 8'd0);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   int doneCount;
   int eofCount;
   int eolCount;

   initial begin
      checks   = 0;
      errors   = 0;
      checking = 1'b0;
      pixIdx   = 0;
      expOvf   = 1'b0;
      expDone  = 1'b0;

      // Reset from power-up, then check the cleared state.
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      tick();
      checking = 1'b1;
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_pix", 32'(m_pix), 32'd0);
      checkOutput("rst_fill", 32'(fill_level), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);

      // Single beat 1,2,3,4 with the sink always ready.
      applyStimulus(1'b1, 1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      checkOutput("sb_pix0", 32'(m_pix), 32'd1);
      checkOutput("sb_sof", 32'(m_sof), 32'd1);
      checkOutput("sb_fill1", 32'(fill_level), 32'd1);
      tick();
      checkOutput("sb_pix1", 32'(m_pix), 32'd2);
      tick();
      checkOutput("sb_pix2", 32'(m_pix), 32'd3);
      tick();
      checkOutput("sb_pix3", 32'(m_pix), 32'd4);
      checkOutput("sb_fill_last", 32'(fill_level), 32'd1);
      tick();
      checkOutput("sb_fill0", 32'(fill_level), 32'd0);

      // Lane masking: lanes 1 and 3 invalid.
      applyStimulus(1'b1, 1'b1, 4'b0101, {8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      checkOutput("mask_l0", 32'(m_pix), 32'hDD);
      tick();
      checkOutput("mask_l1", 32'(m_pix), 32'h00);
      tick();
      checkOutput("mask_l2", 32'(m_pix), 32'hBB);
      tick();
      checkOutput("mask_l3", 32'(m_pix), 32'h00);
      tick();

      // Unknown bits on a flagged-valid lane are stored as zero.
      applyStimulus(1'b1, 1'b1, 4'b1111, {8'h11, 8'hxx, 8'h33, 8'h44}, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      tick();
      tick();
      checkOutput("xlane_zero", 32'(m_pix), 32'h00);
      tick();
      tick();

      // Backpressure: three words held while the sink stalls, then drained.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("bp_valid", 32'(m_valid), 32'd1);
      checkOutput("bp_fill", 32'(fill_level), 32'd3);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 12; i++) tick();
      checkOutput("bp_drained", 32'(fill_level), 32'd0);

      // Fill to DEPTH, then push on full exactly as the head's last lane leaves.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b0);
         tick();
      end
      checkOutput("full_fill", 32'(fill_level), 32'(DEPTH));
      checkOutput("full_no_ovf", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < P - 1; i++) tick();
      applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b1);
      tick();
      checkOutput("full_swap_fill", 32'(fill_level), 32'(DEPTH));
      checkOutput("full_swap_ovf", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b0);
      tick();
      checkOutput("drop_fill", 32'(fill_level), 32'(DEPTH));
      checkOutput("drop_ovf", 32'(overflow), 32'd1);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < DEPTH * P + 4; i++) tick();
      checkOutput("drop_drained", 32'(fill_level), 32'd0);
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);

      // Full frame from a fresh reset: markers and a single done pulse.
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      doneCount = 0;
      eofCount  = 0;
      eolCount  = 0;
      for (int i = 0; i < FRAME / P + 20; i++) begin
         if (i < FRAME / P) applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b1);
         else               applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
         tick();
         if (frame_done === 1'b1) doneCount++;
         if (m_valid === 1'b1 && m_eof === 1'b1) eofCount++;
         if (m_valid === 1'b1 && m_eol === 1'b1) eolCount++;
      end
      checkOutput("frame_done_pulses", 32'(doneCount), 32'd1);
      checkOutput("frame_eof_count", 32'(eofCount), 32'd1);
      checkOutput("frame_eol_count", 32'(eolCount), 32'd2);
      applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      checkOutput("next_frame_sof", 32'(m_sof), 32'd1);
      for (int i = 0; i < P; i++) tick();

      // Reset in the middle of a frame with two words still buffered.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("mid_fill", 32'(fill_level), 32'd2);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
      checkOutput("mid_rst_fill", 32'(fill_level), 32'd0);
      applyStimulus(1'b1, 1'b1, 4'b1111, $urandom(), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      checkOutput("mid_rst_sof", 32'(m_sof), 32'd1);

      // Randomized traffic: duty-cycled beats, random lanes, stalls and rare resets.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom_range(0, 299) != 0),
                       ($urandom_range(0, 4) == 0),
                       P'($urandom()),
                       $urandom(),
                       ($urandom_range(0, 3) != 0));
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < DEPTH * P + 4; i++) tick();
      checkOutput("final_drained", 32'(fill_level), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_stream_serializer.md
Name: conv_stream_serializer

Overview:
- Sink-side counterpart of the P-lane convolution stream. Consumes the P-pixel output beats of the parallel convolver (lane-valid vector plus packed 8-bit pixels).
- Buffers beats in a word FIFO and re-emits them as a 1-pixel/cycle ready/valid raster stream with frame/line markers. This stream feeds frame-buffer writers or the PGM dump path.
- Invalid lanes become pixel value 0, so every frame always carries exactly WIDTH*HEIGHT pixels.

Parameters:
- WIDTH, 256: pixels per line; must be a multiple of P.
- HEIGHT, 256: lines per frame.
- P, 4: lanes per input beat; legal values 1, 2, 4, 8.
- DEPTH, 16: FIFO depth in P-pixel words; power of 2, at least 2.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- beat_valid, input, 1: one P-pixel word is presented this cycle.
- lane_valid, input, P: per-lane validity from the convolver. Lane l is bit l.
- pix_vec, input, P*8: packed pixels. Lane l is pix_vec[l*8 +: 8]. Lane 0 is the leftmost pixel.
- m_ready, input, 1: downstream accepts a pixel.
- m_valid, output, 1: m_pix is valid.
- m_pix, output, 8: serialized pixel.
- m_sof, output, 1: qualifies m_valid; marks pixel (row 0, col 0).
- m_eol, output, 1: qualifies m_valid; marks col WIDTH-1.
- m_eof, output, 1: qualifies m_valid; marks (HEIGHT-1, WIDTH-1).
- frame_done, output, 1: one-cycle pulse, registered, in the cycle after the m_eof pixel transfers.
- overflow, output, 1: sticky; set when a beat is dropped.
- fill_level, output, clog2(DEPTH+1): number of words in the FIFO.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FIFO emptied; fill_level=0.
  - lane index, col and row cleared to 0.
  - m_valid=0, m_sof/m_eol/m_eof=0, m_pix=0.
  - frame_done=0, overflow=0.
  - Reset mid-frame discards all buffered data. The next accepted pixel is the start of a new frame (m_sof=1).
- Push path:
  - When beat_valid=1, a word is built: lane l = pix_vec lane l if lane_valid[l]=1, else 8'd0.
  - A lane whose bits are not all 0/1 in simulation also becomes 0.
  - The word is written at the FIFO tail at the clock edge.
- Pop/serialize:
  - Lane pointer lp walks 0..P-1 over the head word.
  - m_valid = FIFO non-empty; m_pix = head word lane lp.
  - A transfer happens when m_valid && m_ready. On a transfer, lp increments.
  - On lp=P-1 with a transfer, the head word is popped and lp returns to 0.
  - m_pix and the markers depend only on registered state, with no combinational path from m_ready. m_valid and m_pix are held while m_ready=0.
- Latency: a beat pushed into an empty FIFO at edge N drives m_valid=1 with lane 0 in the cycle after edge N.
- Throughput: 1 pixel/cycle output. Sustained input beats every cycle therefore fill the FIFO when P>1. Upstream must duty-cycle; the bench must respect this.
- Full / simultaneous events:
  - A push at fill_level=DEPTH is accepted only if the head word's last lane transfers in the same cycle. Otherwise the beat is dropped, overflow is set, and the FIFO is unchanged.
  - Simultaneous push and pop leaves fill_level unchanged.
  - A push into an empty FIFO is never popped in the same cycle.
- Raster counters:
  - col advances on every transfer. At WIDTH-1 it wraps to 0 and row increments.
  - At (HEIGHT-1, WIDTH-1) both counters wrap to 0, and frame_done pulses in the next cycle.
  - Markers are decoded from the counters of the pixel currently presented.
- Width rules: no arithmetic on pixels. fill_level counts 0..DEPTH inclusive. Pointers wrap modulo DEPTH.
- overflow clears only on reset.

Test Plan:
- Single beat: P=4, lane_valid=4'b1111, pix_vec={8'd4,8'd3,8'd2,8'd1}, m_ready=1 → m_pix sequence 1,2,3,4 on 4 consecutive cycles starting 1 cycle after the push. First pixel has m_sof=1; fill_level goes 1→0 after the 4th transfer.
- Lane masking: lane_valid=4'b0101, pix_vec={8'hAA,8'hBB,8'hCC,8'hDD} → outputs DD,00,BB,00.
- Backpressure: push 3 beats, hold m_ready=0 for 10 cycles → m_valid=1 and m_pix stays at lane 0 of word 0, fill_level=3. Releasing m_ready gives 12 pixels in order with no gaps.
- Overflow: DEPTH=16, m_ready=0, push 17 beats → fill_level=16, overflow=1 from the 17th edge. Draining yields exactly the first 16 words. Also: push on full in the same cycle the head's lane 3 transfers → accepted, overflow stays 0.
- Full frame: WIDTH=8, HEIGHT=2, P=4, 4 beats, m_ready=1 → 16 pixels. m_eol on pixels 7 and 15; m_eof only on pixel 15; frame_done pulses once, the cycle after pixel 15. The next beat's first pixel carries m_sof=1.
- Reset mid-frame: after 5 transfers with 2 words buffered, rst_n=0 for 1 cycle → next cycle m_valid=0, fill_level=0. The next pushed beat's lane 0 carries m_sof=1.
